// File: rtl/bcd_addsub_seq_pkg.sv
// calc_bcd_pkg: shared BCD types, constants, FSM states and counter sizing helper
package calc_bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_BLANK = 4'hF;
  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  typedef enum logic [2:0] {S_IDLE, S_CHK, S_CMP, S_CALC, S_DONE} state_t;
  function automatic int clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bcd_addsub_seq_if.sv
// bcd_addsub_seq_if: start/done handshake, operands and result/flags of the BCD add/sub unit
interface bcd_addsub_seq_if #(parameter int DIGITS = 4);
  logic                  start;
  logic                  op_sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  is_negative;
  logic                  carry_out;
  logic                  invalid;
  modport master (output start, op_sub, a, b,
                  input  busy, done, result, is_negative, carry_out, invalid);
  modport slave  (input  start, op_sub, a, b,
                  output busy, done, result, is_negative, carry_out, invalid);
endinterface

// File: rtl/bcd_addsub_seq_digit.sv
// bcd_digit_addsub: one BCD digit add (+6 correction) or subtract (-6 borrow correction)
module bcd_digit_addsub
  import calc_bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       cin,
  input  logic       sub,
  output bcd_digit_t digit,
  output logic       cout
);
  logic [4:0] s, d;
  // raw binary sum/difference, then decimal correction of the selected one
  always_comb begin
    s = {1'b0, x} + {1'b0, y} + {4'b0, cin};
    d = {1'b0, x} - {1'b0, y} - {4'b0, cin};
    cout = sub ? d[4] : (s > 5'd9);
    digit = sub ? (d[4] ? d[3:0] - 4'd6 : d[3:0]) : ((s > 5'd9) ? s[3:0] + 4'd6 : s[3:0]);
  end
endmodule

// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: digit-serial BCD add/subtract; BCD_LEADING_ZERO_BLANK_EN blanks leading zeros
module bcd_addsub_seq
  import calc_bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic              clk,
  input logic              rst,
  bcd_addsub_seq_if.slave  bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = clog2(DIGITS);
  state_t           state_q, state_d;
  logic [W-1:0]     a_q, b_q, res_sr_q, res_nx, res_out, result_q;
  logic [CW-1:0]    cnt_q;
  logic             op_q, gt_q, lt_q, cy_q, neg_q, co_q, inv_q;
  logic             bad, swap, last, cout;
  bcd_digit_t       da, db, dig;
  assign da     = a_q[{cnt_q, 2'b00} +: 4];
  assign db     = b_q[{cnt_q, 2'b00} +: 4];
  assign swap   = op_q & lt_q;
  assign last   = cnt_q == CW'(DIGITS - 1);
  assign res_nx = {dig, res_sr_q[W-1:4]};
  bcd_digit_addsub u_digit (
    .x     (swap ? b_q[3:0] : a_q[3:0]),
    .y     (swap ? a_q[3:0] : b_q[3:0]),
    .cin   (cy_q),
    .sub   (op_q),
    .digit (dig),
    .cout  (cout)
  );
  // flag any latched digit outside 0..9
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | (a_q[4*i +: 4] > BCD_MAX_DIGIT) | (b_q[4*i +: 4] > BCD_MAX_DIGIT);
  end
  // final result formatting, optionally blanking leading zeros above the LSD
  always_comb begin
    res_out = res_nx;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
        lead = lead & (res_nx[4*i +: 4] == 4'd0);
        if (lead) res_out[4*i +: 4] = BCD_BLANK;
      end
    end
`else
`endif
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = bus.start ? S_CHK : S_IDLE;
      S_CHK:   state_d = bad ? S_DONE : S_CMP;
      S_CMP:   state_d = (cnt_q == '0) ? S_CALC : S_CMP;
      S_CALC:  state_d = last ? S_DONE : S_CALC;
      default: state_d = S_IDLE;
    endcase
  end
  // handshake outputs and registered result/flags
  always_comb begin
    bus.busy        = state_q != S_IDLE;
    bus.done        = state_q == S_DONE;
    bus.result      = result_q;
    bus.is_negative = neg_q;
    bus.carry_out   = co_q;
    bus.invalid     = inv_q;
  end
  // operand latch, compare, digit-serial calc and result update at DONE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; res_sr_q <= '0; result_q <= '0; cnt_q <= '0;
      op_q <= 1'b0; gt_q <= 1'b0; lt_q <= 1'b0; cy_q <= 1'b0;
      neg_q <= 1'b0; co_q <= 1'b0; inv_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && bus.start) begin
        a_q <= bus.a; b_q <= bus.b; op_q <= bus.op_sub;
      end
      if (state_q == S_CHK) begin
        cnt_q <= CW'(DIGITS - 1); gt_q <= 1'b0; lt_q <= 1'b0; cy_q <= 1'b0;
        if (bad) begin
          result_q <= '0; neg_q <= 1'b0; co_q <= 1'b0; inv_q <= 1'b1;
        end
      end
      if (state_q == S_CMP) begin
        if (!gt_q && !lt_q) begin
          gt_q <= da > db; lt_q <= db > da;
        end
        cnt_q <= (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      end
      if (state_q == S_CALC) begin
        a_q <= a_q >> 4; b_q <= b_q >> 4; cy_q <= cout; res_sr_q <= res_nx;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          result_q <= res_out; neg_q <= swap; co_q <= ~op_q & cout; inv_q <= 1'b0;
        end
      end
    end
  end
endmodule
